vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter MAX_VGA_BURST, default 4: consecutive VGA grants allowed while a CPU access waits.
REQ-002 Parameter AW, default 32: address width; DW fixed at 32, byte-enable width 4.
REQ-003 clk  in  1  single clock (VGA pixel clock domain); one clock, reset is synchronous and active-low.
REQ-004 resetn  in  1  synchronous active-low reset.
REQ-005 cpu_addr  in  AW  CPU word address, sampled on a CPU strobe.
REQ-006 cpu_wdata  in  32  CPU write data; cpu_wmask  in  4  byte enables, nonzero = write strobe.
REQ-007 cpu_rstrb  in  1  one-cycle CPU read strobe.
REQ-008 cpu_rdata  out  32  read data, valid while cpu_rdone is high.
REQ-009 cpu_rdone  out  1  one-cycle pulse: CPU read data valid.
REQ-010 cpu_busy  out  1  CPU access captured and not yet complete.
REQ-011 vga_req  in  1  level: VGA fetch pending at vga_addr; vga_addr  in  AW.
REQ-012 vga_rdata  out  32  fetch data; vga_valid  out  1  one-cycle pulse, data valid.
REQ-013 ram_addr  out  AW; ram_wdata  out  32; ram_be  out  4; ram_we  out  1; ram_rdata  in  32  single RAM port, 1-cycle read latency.

Function
REQ-014 CPU strobe (cpu_rstrb or cpu_wmask!=0) with cpu_busy low SHALL be captured into a one-entry pending register; cpu_busy high from the next cycle.
REQ-015 Strobes while cpu_busy is high SHALL be ignored.
REQ-016 cpu_wmask!=0 together with cpu_rstrb SHALL be treated as a write; rstrb ignored.
REQ-017 FSM states IDLE, GNT_VGA, GNT_CPU_RD, GNT_CPU_WR; state is registered, RAM outputs driven combinationally from the current state and the grant decision.
REQ-018 Arbitration each cycle: only one requester -> it is granted; both -> VGA unless vga_streak == MAX_VGA_BURST, then CPU.
REQ-019 vga_streak SHALL increment on each VGA grant while a CPU access is pending, saturate at MAX_VGA_BURST, and clear on a CPU grant or when no CPU access is pending.
REQ-020 VGA grant in cycle N: ram_addr=vga_addr, ram_we=0; vga_valid=1 and vga_rdata=ram_rdata in cycle N+1.
REQ-021 CPU read grant in cycle N: ram_addr=captured addr, ram_we=0; cpu_rdone=1, cpu_rdata=ram_rdata in N+1; cpu_busy falls in N+1.
REQ-022 CPU write grant in cycle N: ram_we=1, ram_be=captured mask, ram_wdata=captured data; cpu_busy low in N+1; no cpu_rdone.
REQ-023 A captured CPU access SHALL not be granted before the cycle after capture (minimum CPU latency: strobe to grant 1 cycle).
REQ-024 Back-to-back grants SHALL be allowed every cycle; the response pipeline is a 1-bit owner register plus valid.
REQ-025 Idle cycle (no grant): ram_we=0, ram_be=0, ram_addr holds last value.
REQ-026 Worst-case CPU wait with vga_req held high SHALL be MAX_VGA_BURST VGA grants, then the CPU grant.
REQ-027 vga_req dropping while a VGA read is in flight SHALL still produce the vga_valid pulse.

Reset
REQ-028 resetn low at a clock edge SHALL set state=IDLE, pending cleared, vga_streak=0, and the response owner/valid registers cleared.
REQ-029 Reset values: cpu_busy=0, cpu_rdone=0, vga_valid=0, ram_we=0, ram_be=0, cpu_rdata=0, vga_rdata=0.
REQ-030 Reset mid-access SHALL discard the access: no rdone/valid pulse in the cycle after reset, and a pending write is never issued.

Structure
REQ-031 Shared package vram_pkg SHALL hold the state enum, owner enum (OWN_VGA, OWN_CPU), and the default MAX_VGA_BURST.
REQ-032 No sub-module; single flat block instantiated between the processor, the vga block and the mem port 1 in top.

Verification
REQ-033 CPU write addr 0x10, wdata 0xDEADBEEF, wmask 0xF, vga_req=0 -> next cycle ram_we=1, ram_be=0xF, ram_addr=0x10; cpu_busy low one cycle later.
REQ-034 CPU read addr 0x10 after that write, model RAM -> cpu_rdone pulses 2 cycles after the strobe with cpu_rdata=0xDEADBEEF.
REQ-035 vga_req held high, addr incrementing from 0x100, then CPU read strobe -> exactly 4 VGA grants, then 1 CPU grant, then VGA resumes; every VGA grant yields vga_valid one cycle later.
REQ-036 cpu_rstrb and cpu_wmask=0x3 in the same cycle -> single write with ram_be=0x3, no cpu_rdone.
REQ-037 Second strobe while cpu_busy high -> ignored; exactly one RAM access is issued.
REQ-038 resetn low in the cycle a CPU read is granted -> no cpu_rdone, cpu_busy=0, all outputs at reset values.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM arbiter.
//   state_e : grant decision / registered grant state
//   owner_e : which requester owns the read response in flight
//   MAX_VGA_BURST_DEF : default number of VGA grants allowed while a CPU access waits
package vram_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GNT_VGA    = 2'd1,
        GNT_CPU_RD = 2'd2,
        GNT_CPU_WR = 2'd3
    } state_e;

    typedef enum logic {
        OWN_VGA = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

    localparam int unsigned MAX_VGA_BURST_DEF = 4;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between a CPU (one-entry pending access) and a VGA
// fetch engine. VGA has priority but may only take MAX_VGA_BURST consecutive
// grants while a CPU access waits. RAM read latency is one cycle.
// Ports:
//   clk, resetn                  : clock, synchronous active-low reset
//   cpu_addr/wdata/wmask/rstrb   : CPU strobe interface (wmask != 0 means write)
//   cpu_rdata/rdone/busy         : CPU read response and busy flag
//   vga_req/vga_addr             : VGA fetch request (level) and address
//   vga_rdata/vga_valid          : VGA fetch response
//   ram_addr/wdata/be/we/rdata   : single RAM port
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned MAX_VGA_BURST = MAX_VGA_BURST_DEF,
    parameter int unsigned AW            = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_wmask,
    input  logic          cpu_rstrb,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_rdone,
    output logic          cpu_busy,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic [31:0]   vga_rdata,
    output logic          vga_valid,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    output logic [3:0]    ram_be,
    output logic          ram_we,
    input  logic [31:0]   ram_rdata
);

    localparam int SW = (MAX_VGA_BURST < 1) ? 1 : $clog2(MAX_VGA_BURST + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_VGA_BURST);

    state_e        state_q, state_d;
    owner_e        rsp_own_q, rsp_own_d;
    logic          pend_vld_q, pend_vld_d;
    logic          pend_we_q, pend_we_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [31:0]   pend_wdata_q, pend_wdata_d;
    logic [3:0]    pend_be_q, pend_be_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          cpu_stb;
    logic          cpu_gnt;
    logic          rsp_vld;

    assign cpu_stb = cpu_rstrb || (cpu_wmask != 4'b0000);

    // ---- state register ----
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            rsp_own_q  <= OWN_VGA;
            pend_vld_q <= 1'b0;
            streak_q   <= '0;
        end else begin
            state_q    <= state_d;
            rsp_own_q  <= rsp_own_d;
            pend_vld_q <= pend_vld_d;
            streak_q   <= streak_d;
        end
    end

    // Payload registers carry no reset: pend_vld_q qualifies them.
    always_ff @(posedge clk) begin
        pend_we_q    <= pend_we_d;
        pend_addr_q  <= pend_addr_d;
        pend_wdata_q <= pend_wdata_d;
        pend_be_q    <= pend_be_d;
        ram_addr_q   <= ram_addr_d;
    end

    // ---- next-state / grant decision ----
    // state_d is this cycle's grant; no grant is issued while reset is asserted
    // so a pending write cannot slip out in the reset cycle.
    always_comb begin
        state_d = IDLE;
        if (resetn) begin
            if (pend_vld_q && (!vga_req || streak_q == STREAK_MAX)) begin
                state_d = pend_we_q ? GNT_CPU_WR : GNT_CPU_RD;
            end else if (vga_req) begin
                state_d = GNT_VGA;
            end
        end
    end

    assign cpu_gnt = (state_d == GNT_CPU_RD) || (state_d == GNT_CPU_WR);

    // ---- pending CPU access, streak counter, response owner ----
    always_comb begin
        pend_vld_d   = pend_vld_q;
        pend_we_d    = pend_we_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        pend_be_d    = pend_be_q;
        if (cpu_gnt) begin
            pend_vld_d = 1'b0;
        end
        // A grant implies pend_vld_q, so capture and retire never coincide.
        if (cpu_stb && !pend_vld_q) begin
            pend_vld_d   = 1'b1;
            pend_we_d    = (cpu_wmask != 4'b0000);
            pend_addr_d  = cpu_addr;
            pend_wdata_d = cpu_wdata;
            pend_be_d    = cpu_wmask;
        end

        streak_d = streak_q;
        if (cpu_gnt || !pend_vld_q) begin
            streak_d = '0;
        end else if (state_d == GNT_VGA && streak_q != STREAK_MAX) begin
            streak_d = streak_q + SW'(1);
        end

        rsp_own_d = (state_d == GNT_CPU_RD) ? OWN_CPU : OWN_VGA;
    end

    // ---- RAM port outputs ----
    always_comb begin
        ram_addr = ram_addr_q;
        ram_we   = 1'b0;
        ram_be   = 4'b0000;
        unique case (state_d)
            GNT_VGA:    ram_addr = vga_addr;
            GNT_CPU_RD: ram_addr = pend_addr_q;
            GNT_CPU_WR: begin
                ram_addr = pend_addr_q;
                ram_we   = 1'b1;
                ram_be   = pend_be_q;
            end
            default: ;
        endcase
        ram_addr_d = ram_addr;
    end

    assign ram_wdata = pend_wdata_q;
    assign cpu_busy  = pend_vld_q;

    // ---- response stage ----
    // The registered grant state doubles as the response valid: only read
    // grants return data; rsp_own_q says whose data it is.
    assign rsp_vld   = (state_q == GNT_VGA) || (state_q == GNT_CPU_RD);
    assign vga_valid = rsp_vld && (rsp_own_q == OWN_VGA);
    assign cpu_rdone = rsp_vld && (rsp_own_q == OWN_CPU);
    assign vga_rdata = vga_valid ? ram_rdata : 32'h0;
    assign cpu_rdata = cpu_rdone ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: directed scenarios plus randomized traffic,
// every cycle checked against a transaction-level reference model.
module tb_vram_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wmask;
    logic        cpu_rstrb, cpu_rdone, cpu_busy;
    logic        vga_req, vga_valid;
    logic [31:0] vga_addr, vga_rdata;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_be;
    logic        ram_we;

    always #5 clk = ~clk;

    vram_arbiter #(.MAX_VGA_BURST(MAXB), .AW(32)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
        .cpu_rstrb(cpu_rstrb), .cpu_rdata(cpu_rdata), .cpu_rdone(cpu_rdone),
        .cpu_busy(cpu_busy), .vga_req(vga_req), .vga_addr(vga_addr),
        .vga_rdata(vga_rdata), .vga_valid(vga_valid), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
    );

    // RAM attached to the DUT: 64 words, 1-cycle read latency, byte writes.
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr[5:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        ram_rdata <= mem[ram_addr[5:0]];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference model: one pending CPU slot, a count of VGA grants taken
    // while the CPU waits, and the read that returns next cycle.
    bit          m_pend, m_pend_wr;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    int          m_streak;
    int          m_prev;        // 0 none, 1 VGA read, 2 CPU read returning
    logic [31:0] m_prev_data;
    logic [31:0] m_last_addr;
    bit          m_addr_known;
    int          last_gnt;      // 0 none, 1 VGA, 2 CPU read, 3 CPU write

    task automatic cyc(input bit rn, input bit rs, input logic [3:0] wm,
                       input logic [31:0] ca, input logic [31:0] wd,
                       input bit vr, input logic [31:0] va);
        int          g;
        bit          old_pend;
        logic [31:0] exp_addr;
        @(negedge clk);
        resetn = rn; cpu_rstrb = rs; cpu_wmask = wm; cpu_addr = ca;
        cpu_wdata = wd; vga_req = vr; vga_addr = va;
        #1;
        check_eq("vga_valid", vga_valid, 32'(m_prev == 1));
        check_eq("vga_rdata", vga_rdata, (m_prev == 1) ? m_prev_data : 32'h0);
        check_eq("cpu_rdone", cpu_rdone, 32'(m_prev == 2));
        check_eq("cpu_rdata", cpu_rdata, (m_prev == 2) ? m_prev_data : 32'h0);
        check_eq("cpu_busy", cpu_busy, 32'(m_pend));

        g = 0;
        if (rn) begin
            if (m_pend && (!vr || m_streak >= MAXB)) g = m_pend_wr ? 3 : 2;
            else if (vr) g = 1;
        end
        exp_addr = (g == 1) ? va : (g >= 2) ? m_addr : m_last_addr;
        if (g != 0 || m_addr_known) check_eq("ram_addr", ram_addr, exp_addr);
        check_eq("ram_we", ram_we, 32'(g == 3));
        check_eq("ram_be", ram_be, (g == 3) ? 32'(m_be) : 32'h0);
        if (g == 3) check_eq("ram_wdata", ram_wdata, m_wdata);
        last_gnt = g;

        if (g != 0) begin m_last_addr = exp_addr; m_addr_known = 1; end
        m_prev_data = ref_mem[exp_addr[5:0]];
        if (g == 3)
            for (int b = 0; b < 4; b++)
                if (m_be[b]) ref_mem[m_addr[5:0]][8*b +: 8] = m_wdata[8*b +: 8];

        if (!rn) begin
            m_pend = 0; m_streak = 0; m_prev = 0;
        end else begin
            if (g >= 2 || !m_pend) m_streak = 0;
            else if (g == 1 && m_streak < MAXB) m_streak++;
            m_prev = (g == 1) ? 1 : (g == 2) ? 2 : 0;
            old_pend = m_pend;
            if (g >= 2) m_pend = 0;
            if ((rs || wm != 4'h0) && !old_pend) begin
                m_pend = 1; m_pend_wr = (wm != 4'h0);
                m_addr = ca; m_wdata = wd; m_be = wm;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        int  nv, ncpu;
        bit  seen_cpu, resumed;
        for (int i = 0; i < 64; i++) begin
            mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        m_pend = 0; m_pend_wr = 0; m_streak = 0; m_prev = 0; m_addr_known = 0;
        m_addr = 0; m_wdata = 0; m_be = 0; m_prev_data = 0; m_last_addr = 0;
        resetn = 0; cpu_rstrb = 0; cpu_wmask = 0; cpu_addr = 0; cpu_wdata = 0;
        vga_req = 0; vga_addr = 0;
        repeat (2) @(posedge clk);

        // Reset state
        cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0);
        idle(1);
        check_eq("rst_busy", cpu_busy, 32'h0);
        check_eq("rst_we", ram_we, 32'h0);
        check_eq("rst_be", ram_be, 32'h0);
        check_eq("rst_rdata", cpu_rdata, 32'h0);

        // Write 0x10 <- DEADBEEF, then read it back
        cyc(1, 0, 4'hF, 32'h10, 32'hDEADBEEF, 0, 32'h0);
        idle(1);
        check_eq("wr_we", ram_we, 32'h1);
        check_eq("wr_be", ram_be, 32'hF);
        check_eq("wr_addr", ram_addr, 32'h10);
        idle(1);
        check_eq("wr_busy_low", cpu_busy, 32'h0);
        cyc(1, 1, 4'h0, 32'h10, 32'h0, 0, 32'h0);
        idle(2);
        check_eq("rd_done", cpu_rdone, 32'h1);
        check_eq("rd_data", cpu_rdata, 32'hDEADBEEF);

        // VGA streaming with a CPU read inserted
        cyc(1, 0, 4'h0, 32'h0, 32'h0, 1, 32'h100);
        cyc(1, 0, 4'h0, 32'h0, 32'h0, 1, 32'h101);
        cyc(1, 1, 4'h0, 32'h10, 32'h0, 1, 32'h102);
        nv = 0; seen_cpu = 0; resumed = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, 4'h0, 32'h0, 32'h0, 1, 32'h103 + 32'(i));
            if (!seen_cpu) begin
                if (dut.ram_we == 1'b0 && ram_addr == 32'h103 + 32'(i)) nv++;
                else if (ram_addr == 32'h10) seen_cpu = 1;
            end else if (!resumed) begin
                resumed = 1;
                check_eq("vga_resume_addr", ram_addr, 32'h103 + 32'(i));
            end
        end
        check_eq("vga_burst_len", 32'(nv), 32'(MAXB));
        check_eq("cpu_after_burst", 32'(seen_cpu), 32'h1);
        idle(2);

        // Read strobe together with write mask: write only
        cyc(1, 1, 4'h3, 32'h11, 32'hCAFEF00D, 0, 32'h0);
        idle(1);
        check_eq("mix_we", ram_we, 32'h1);
        check_eq("mix_be", ram_be, 32'h3);
        idle(1);
        check_eq("mix_no_rdone", cpu_rdone, 32'h0);
        cyc(1, 1, 4'h0, 32'h11, 32'h0, 0, 32'h0);
        idle(2);
        check_eq("mix_rdback", cpu_rdata, (init_word(17) & 32'hFFFF0000) | 32'h0000F00D);

        // Second strobe while busy is ignored
        cyc(1, 1, 4'h0, 32'h10, 32'h0, 1, 32'h0);
        ncpu = 0;
        cyc(1, 0, 4'hF, 32'h20, 32'h1234, 1, 32'h1);
        for (int i = 0; i < 6; i++) begin
            if (ram_addr == 32'h10 || ram_addr == 32'h20) ncpu++;
            cyc(1, 0, 4'h0, 32'h0, 32'h0, 1, 32'h2 + 32'(i));
        end
        check_eq("busy_single_access", 32'(ncpu), 32'h1);
        check_eq("busy_ignored_wr", mem[32], init_word(32));
        idle(2);

        // Reset in the cycle a CPU read would be granted
        cyc(1, 1, 4'h0, 32'h10, 32'h0, 0, 32'h0);
        cyc(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0);
        check_eq("rstg_we", ram_we, 32'h0);
        idle(1);
        check_eq("rstg_rdone", cpu_rdone, 32'h0);
        check_eq("rstg_busy", cpu_busy, 32'h0);
        check_eq("rstg_valid", vga_valid, 32'h0);
        check_eq("rstg_rdata", cpu_rdata, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 99) != 0,
                $urandom_range(0, 3) == 0,
                ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                32'($urandom_range(0, 63)), $urandom,
                $urandom_range(0, 9) < 7,
                32'($urandom_range(0, 63)));
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
